// File: rtl/axi_regbank_sync.sv
// axi_regbank_sync: AXI4-Lite slave register bank with byte strobes, a
// per-register read-only mask mapping status inputs into the address space,
// and an optional shadow stage committed to the active copy on update_strobe.
//
// Ports:
//   ACLK, ARESETN      clock (rising edge), async active-low reset
//   S_AXI_AW*/W*/B*    AXI4-Lite write channels (AWPROT ignored)
//   S_AXI_AR*/R*       AXI4-Lite read channels (ARPROT ignored)
//   status_in          NUM_REGS slices of DW bits, read back for RO registers
//   ctrl_out           NUM_REGS slices of active values, RO slots drive 0
//   update_strobe      shadow -> active transfer request (shadow mode only)
//   update_pending     shadow holds an uncommitted write

// One register slot: shadow + active copies with byte-lane writes.
module axi_regbank_slot #(
  parameter int DW     = 32,
  parameter bit SHADOW = 1'b1,
  parameter bit RO     = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [DW/8-1:0] strb,
  input  logic [DW-1:0]   wdata,
  input  logic            update,
  output logic [DW-1:0]   rd_val,
  output logic [DW-1:0]   act
);
  logic [DW-1:0] sh_q, act_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      act_q <= '0;
    end else begin
      // Transfer uses the pre-edge shadow, so a write landing on the same
      // edge stays in shadow only.
      if (SHADOW && update) act_q <= sh_q;
      for (int b = 0; b < DW/8; b++) begin
        if (wr_en && strb[b]) begin
          if (SHADOW) sh_q[8*b +: 8]  <= wdata[8*b +: 8];
          else        act_q[8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rd_val = SHADOW ? sh_q : act_q;
  assign act    = RO ? '0 : act_q;
endmodule

module axi_regbank_sync #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter bit SHADOW_MODE        = 1'b1
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_out,
  input  logic                                   update_strobe,
  output logic                                   update_pending
);
  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int OFFW = $clog2(DW/8);
  localparam int IDXW = $clog2(NUM_REGS);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  logic            aw_rdy, b_vld, ar_rdy, r_vld, pend;
  logic [1:0]      b_resp, r_resp;
  logic [DW-1:0]   r_data, rd_word;
  logic [IDXW-1:0] wr_idx, rd_idx;
  logic            wr_hi0, rd_hi0, wr_idx_ok, rd_idx_ok, wr_ok, rd_ok;
  logic            wr_commit, rd_commit;
  logic [NUM_REGS-1:0]         wr_en;
  logic [NUM_REGS-1:0][DW-1:0] rd_vals, act;

  // ---- address decode ----
  assign wr_idx = S_AXI_AWADDR[IDXW+OFFW-1:OFFW];
  assign rd_idx = S_AXI_ARADDR[IDXW+OFFW-1:OFFW];
  assign wr_hi0 = (S_AXI_AWADDR >> (IDXW+OFFW)) == '0;
  assign rd_hi0 = (S_AXI_ARADDR >> (IDXW+OFFW)) == '0;

  // Non-power-of-two banks leave holes at the top of the index range.
  if ((1 << IDXW) == NUM_REGS) begin : g_pow2
    assign wr_idx_ok = 1'b1;
    assign rd_idx_ok = 1'b1;
  end else begin : g_npow2
    assign wr_idx_ok = wr_idx < IDXW'(NUM_REGS);
    assign rd_idx_ok = rd_idx < IDXW'(NUM_REGS);
  end

  assign wr_ok = wr_hi0 && wr_idx_ok && !RO_MASK[wr_idx];
  assign rd_ok = rd_hi0 && rd_idx_ok;

  // Ready is a registered one-cycle pulse; the handshake edge commits.
  assign wr_commit = aw_rdy && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_commit = ar_rdy && S_AXI_ARVALID;

  // ---- register slots ----
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    assign wr_en[k] = wr_commit && wr_ok && (wr_idx == IDXW'(k));
    axi_regbank_slot #(.DW(DW), .SHADOW(SHADOW_MODE), .RO(RO_MASK[k])) u_slot (
      .clk(ACLK), .rst_n(ARESETN), .wr_en(wr_en[k]), .strb(S_AXI_WSTRB),
      .wdata(S_AXI_WDATA), .update(update_strobe), .rd_val(rd_vals[k]),
      .act(act[k]));
    assign ctrl_out[k*DW +: DW] = act[k];
  end

  // ---- write channel ----
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_rdy <= 1'b0;
      b_vld  <= 1'b0;
      b_resp <= OKAY;
    end else begin
      aw_rdy <= !aw_rdy && S_AXI_AWVALID && S_AXI_WVALID && !b_vld;
      if (wr_commit) begin
        b_vld  <= 1'b1;
        b_resp <= wr_ok ? OKAY : SLVERR;
      end else if (b_vld && S_AXI_BREADY) begin
        b_vld  <= 1'b0;
      end
    end
  end

  // Pending: a committed write with any strobe wins over a same-edge transfer.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                                    pend <= 1'b0;
    else if (SHADOW_MODE && wr_commit && wr_ok && |S_AXI_WSTRB) pend <= 1'b1;
    else if (SHADOW_MODE && update_strobe)           pend <= 1'b0;
  end

  // ---- read channel ----
  always_comb begin
    rd_word = '0;
    if (rd_ok) rd_word = RO_MASK[rd_idx] ? status_in[rd_idx*DW +: DW] : rd_vals[rd_idx];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ar_rdy <= 1'b0;
      r_vld  <= 1'b0;
      r_resp <= OKAY;
      r_data <= '0;
    end else begin
      ar_rdy <= !ar_rdy && S_AXI_ARVALID && !r_vld;
      if (rd_commit) begin
        r_vld  <= 1'b1;
        r_data <= rd_word;
        r_resp <= rd_ok ? OKAY : SLVERR;
      end else if (r_vld && S_AXI_RREADY) begin
        r_vld  <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY  = aw_rdy;
  assign S_AXI_WREADY   = aw_rdy;
  assign S_AXI_BVALID   = b_vld;
  assign S_AXI_BRESP    = b_resp;
  assign S_AXI_ARREADY  = ar_rdy;
  assign S_AXI_RVALID   = r_vld;
  assign S_AXI_RRESP    = r_resp;
  assign S_AXI_RDATA    = r_data;
  assign update_pending = pend;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[OFFW-1:0],
                       S_AXI_ARADDR[OFFW-1:0], status_in, update_strobe};
endmodule
